// File: rtl/mem_ram_bist_if.sv
// mem_ram_bist_if: functional RAM ports and BIST control/status.
// master drives requests; slave is the RAM with its BIST engine.
interface mem_ram_bist_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 2
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WIDTH-1:0]  mem_rd_data;
  logic              mem_rd_valid;
  logic              bist_start;
  logic              bist_err_inj;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] bist_fail_addr;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_en, mem_rd_addr,
    output bist_start, bist_err_inj,
    input  mem_rd_data, mem_rd_valid,
    input  bist_busy, bist_done,
    input  bist_fail, bist_fail_addr
  );

  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_en, mem_rd_addr,
    input  bist_start, bist_err_inj,
    output mem_rd_data, mem_rd_valid,
    output bist_busy, bist_done,
    output bist_fail, bist_fail_addr
  );
endinterface

// File: rtl/mem_ram_bist.sv
// mem_ram_bist: simple dual-port RAM, pipelined read with valid
// strobe, and a March-style BIST engine on the functional clock.
module mem_ram_bist #(
  parameter int WIDTH      = 64,
  parameter int ADDR_W     = 2,
  parameter int RD_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  mem_ram_bist_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("mem_ram_bist: RD_LATENCY must be 1..4");
  end
  if (WIDTH < 1 || WIDTH > 512) begin : g_bad_width
    $error("mem_ram_bist: WIDTH must be 1..512");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0W1,
    S_R1W0,
    S_R0
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_cnt;
  logic [WIDTH-1:0]  r_bq;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic              r_vpipe [RD_LATENCY];
  logic [WIDTH-1:0]  r_dpipe [RD_LATENCY];

  logic             w_busy;
  logic             w_start;
  logic             w_frd;
  logic             w_fwr;
  logic             w_cmp_slot;
  logic             w_last;
  logic             w_step;
  logic             w_end;
  logic             w_bwr;
  logic             w_bissue;
  logic             w_bcmp;
  logic [WIDTH-1:0] w_bpat;
  logic [WIDTH-1:0] w_bexp;
  logic [WIDTH-1:0] w_inj;
  logic [WIDTH-1:0] w_bwdata;

  assign w_busy     = (r_state != S_IDLE);
  assign w_start    = (r_state == S_IDLE) & bus.bist_start;
  assign w_frd      = bus.mem_rd_en & ~w_busy & ~w_start;
  assign w_fwr      = bus.mem_wr_en & ~w_busy;
  assign w_cmp_slot = (r_cnt == LAT);
  assign w_end      = w_step & w_last;
  assign w_bwdata   = w_bpat ^ w_inj;

  // BIST state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // BIST phase sequencing: each phase ends on its last address step
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.bist_start) w_next = S_W0;
      S_W0:   if (w_end) w_next = S_R0W1;
      S_R0W1: if (w_end) w_next = S_R1W0;
      S_R1W0: if (w_end) w_next = S_R0;
      S_R0:   if (w_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // BIST per-state actions: write, read issue, compare, patterns
  always_comb begin
    w_bwr    = 1'b0;
    w_bissue = 1'b0;
    w_bcmp   = 1'b0;
    w_step   = 1'b0;
    w_bpat   = '0;
    w_bexp   = '0;
    w_last   = (r_addr == A_LAST);
    w_inj    = '0;
    w_inj[0] = bus.bist_err_inj;
    unique case (r_state)
      S_W0: begin
        w_bwr  = 1'b1;
        w_step = 1'b1;
      end
      S_R0W1: begin
        w_bissue = (r_cnt == 3'd0);
        w_bcmp   = w_cmp_slot;
        w_bwr    = w_cmp_slot;
        w_step   = w_cmp_slot;
        w_bpat   = '1;
      end
      S_R1W0: begin
        w_bissue = (r_cnt == 3'd0);
        w_bcmp   = w_cmp_slot;
        w_bwr    = w_cmp_slot;
        w_step   = w_cmp_slot;
        w_bexp   = '1;
        w_last   = (r_addr == '0);
      end
      S_R0: begin
        w_bissue = (r_cnt == 3'd0);
        w_bcmp   = w_cmp_slot;
        w_step   = w_cmp_slot;
      end
      default: ;
    endcase
  end

  // BIST address walk and per-address latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_busy) begin
      if (r_state != S_W0)
        r_cnt <= w_cmp_slot ? 3'd0 : r_cnt + 3'd1;
      if (w_step) begin
        if (w_end)
          r_addr <= (r_state == S_R0W1) ? A_LAST : '0;
        else if (r_state == S_R1W0)
          r_addr <= r_addr - 1'b1;
        else
          r_addr <= r_addr + 1'b1;
      end
    end
  end

  // BIST status: done/fail are sticky until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else if (w_start) begin
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      if (w_bcmp && (r_bq != w_bexp)) begin
        r_fail <= 1'b1;
        if (!r_fail) r_fail_addr <= r_addr;
      end
      if ((r_state == S_R0) && w_end) r_done <= 1'b1;
    end
  end

  // Array write port (BIST owns it while busy) and BIST read capture
  always_ff @(posedge clk) begin
    if (w_bwr)
      r_mem[r_addr] <= w_bwdata;
    else if (w_fwr)
      r_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (w_bissue)
      r_bq <= r_mem[r_addr];
  end

  // Functional read pipeline; data stages hold unless a valid advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_vpipe[i] <= 1'b0;
        r_dpipe[i] <= '0;
      end
    end else begin
      r_vpipe[0] <= w_frd;
      if (w_frd) r_dpipe[0] <= r_mem[bus.mem_rd_addr];
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1] & ~w_start;
        if (r_vpipe[i-1] && !w_start)
          r_dpipe[i] <= r_dpipe[i-1];
      end
    end
  end

  assign bus.mem_rd_data    = r_dpipe[RD_LATENCY-1];
  assign bus.mem_rd_valid   = r_vpipe[RD_LATENCY-1];
  assign bus.bist_busy      = w_busy;
  assign bus.bist_done      = r_done;
  assign bus.bist_fail      = r_fail;
  assign bus.bist_fail_addr = r_fail_addr;

endmodule

// File: doc/mem_ram_bist.md
Name: mem_ram_bist

Overview:
- Parametrised successor to the fixed 4x64 vendor memory model: a simple dual-port RAM with configurable width, depth and read latency.
- Adds a read-valid strobe and a built-in March-style BIST engine on the functional clock, replacing the fake BIST loopback.
- Instantiated by the router buffer wrappers in place of fixed-size vendor models; BIST is run by the test controller after reset.

Parameters:
- WIDTH, 64: data width in bits, 1..512.
- ADDR_W, 2: address width. DEPTH = 2**ADDR_W entries.
- RD_LATENCY, 2: read latency in cycles, from rd_en sample to data valid. Legal range 1..4; any other value is an elaboration error.

Ports:
- clk  input  1  Single clock for all logic, rising edge.
- rst  input  1  Asynchronous, active-high reset.
- mem_wr_en  input  1  Functional write enable.
- mem_wr_addr  input  ADDR_W  Write address.
- mem_wr_data  input  WIDTH  Write data.
- mem_rd_en  input  1  Functional read enable.
- mem_rd_addr  input  ADDR_W  Read address.
- mem_rd_data  output  WIDTH  Read data; holds its last value between reads.
- mem_rd_valid  output  1  One-cycle pulse; mem_rd_data is valid in this cycle.
- bist_start  input  1  Pulse to start BIST. Sampled only in IDLE.
- bist_err_inj  input  1  Test-only: inverts bit 0 of every BIST write.
- bist_busy  output  1  BIST run in progress.
- bist_done  output  1  Sticky run-complete flag; cleared by the next accepted start.
- bist_fail  output  1  Sticky mismatch flag for the current or last run.
- bist_fail_addr  output  ADDR_W  Address of the first mismatch in the run.

Behaviour:
- Reset:
  - mem_rd_data=0, mem_rd_valid=0, bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0.
  - Read pipeline is flushed and the FSM goes to IDLE.
  - Array contents are not reset; their values are unspecified after reset.
- Write: mem_wr_en sampled at edge k updates the entry at edge k.
- Read:
  - mem_rd_en sampled at edge k gives data at edge k+RD_LATENCY-1 (visible the following cycle), with mem_rd_valid=1 for exactly that cycle.
  - A read issued every cycle is fully pipelined: one result per cycle.
- Read/write collision: same-edge read and write to the same address returns the old data (read-before-write).
- Functional ports during BIST:
  - While bist_busy=1, mem_wr_en and mem_rd_en are ignored.
  - In-flight functional reads are discarded from the start edge: no mem_rd_valid pulse while busy.
  - mem_rd_data is not driven by BIST reads.
- FSM states: IDLE -> W0 -> R0W1 -> R1W0 -> R0 -> IDLE.
  - bist_start=1 in IDLE at edge s: busy=1, done=0, fail=0, fail_addr=0; enter W0 at address 0.
  - W0: ascending address order; write all-zeros, one address per cycle (DEPTH cycles).
  - R0W1: ascending. Per address, issue the read, wait RD_LATENCY cycles, compare against all-zeros, and in the compare cycle write all-ones and advance. Costs RD_LATENCY+1 cycles per address.
  - R1W0: descending from DEPTH-1. Expect all-ones, write all-zeros. Same timing as R0W1.
  - R0: ascending; expect all-zeros, no write.
  - After the final R0 compare: busy=0, done=1, return to IDLE.
- Run length: total cycles from s to done = DEPTH + 3*DEPTH*(RD_LATENCY+1). A run is never shortened by a failure.
- Mismatch:
  - Any bit differing sets bist_fail (sticky).
  - bist_fail_addr captures the address of the first mismatch only; later mismatches do not update it.
- bist_err_inj: when 1, bit 0 of the BIST write pattern is inverted at the moment of the write. Expected values are never inverted.
- bist_start while busy is ignored; a start pulse while done=1 begins a new run.
- Reset asserted mid-run: behaves as full reset; the run is abandoned and done stays 0.
- Address counters in BIST wrap only at phase boundaries. Functional addresses are always in range by construction, since DEPTH = 2**ADDR_W.

Test Plan:
- Defaults. Write addr1=0x0123_4567_89AB_CDEF at edge 10; read addr1 at edge 11 -> mem_rd_valid=1 with that data in the cycle after edge 12, valid low at all other times.
- Defaults. Read on every cycle, addrs 0,1,2,3 from edge 20 -> four consecutive valid cycles; data in address order.
- Defaults. Same edge: write addr2=0xFFFF..FF (old value 0x5) and read addr2 -> returned data 0x5. A subsequent read returns 0xFFFF..FF.
- Defaults. bist_start pulse at edge s, err_inj=0 -> busy for 40 cycles; done=1 and fail=0 after edge s+40; no functional mem_rd_valid while busy.
- Defaults, err_inj=1 for the whole run -> fail=1, fail_addr=0, done still at s+40. Repeat with RD_LATENCY=1 -> done at s+28.
- Reset asserted at s+15 during a run -> busy=0, done=0, fail=0 immediately. A new start then completes normally in 40 cycles.
